seg7_bcd_counter: RTL and testbench
===================================

# seg7_bcd_counter

Parametrised N-digit BCD up/down counter with a time-multiplexed common-segment 7-segment display driver. It is the general successor of the fixed two-digit 0–99 display counter. It adds configurable digit count, count direction, run/pause, synchronous clear, parallel load, leading-zero blanking and a wrap pulse. It sits between board buttons/switches and the segment/digit pins of the display module.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits and digit-select lines (legal 1..8)
- TICK_WAIT, 27_000_000, i_clk cycles per count step (1 s at 27 MHz, ≥2)
- SCAN_WAIT, 27_000, i_clk cycles each digit is driven (1 ms at 27 MHz, ≥2)
- BLANK_LZ, 0, 1 = blank leading zero digits; digit 0 (units) is never blanked

Ports:
- i_clk  in  1  clock
- w_rst  in  1  reset w_rst, asynchronous, active-high; clock i_clk
- i_run  in  1  count enable; 0 pauses prescaler and count
- i_up  in  1  direction: 1 = increment, 0 = decrement
- i_clr  in  1  synchronous clear of count and prescaler
- i_load  in  1  synchronous parallel load
- i_load_val  in  4*DIGITS  BCD load value, digit k at bits [4k+3:4k]
- o_bcd  out  4*DIGITS  current count, same packing, digit 0 = units
- o_wrap  out  1  one-cycle pulse on wrap-around
- o_seg  out  8  segments {a,b,c,d,e,f,g,dp}, 1 = lit, dp always 0
- o_dig  out  DIGITS  digit select, active-low one-hot

## Operation
- Prescaler: 0..TICK_WAIT-1, width $clog2(TICK_WAIT).
  - Advances only while i_run=1 and holds while i_run=0.
  - A step fires on the edge where prescaler==TICK_WAIT-1 and i_run=1; the prescaler returns to 0 on that edge.
- Priority per edge: i_clr > i_load > step.
  - Clear: count=0 and prescaler=0.
  - Load: count=i_load_val and prescaler=0. A nibble >9 is stored as 9.
  - A step is discarded in a cycle where clear or load wins.
- Up step: units +1 with decimal carry ripple; digit 9→0 carries into the next digit.
  - All-9s→all-0s sets o_wrap=1 for that one cycle.
- Down step: units −1 with borrow ripple; digit 0→9 borrows from the next digit.
  - All-0s→all-9s sets o_wrap=1.
- i_up is sampled only at the step edge. Changing direction mid-period does not reset the prescaler.
- Scan: scan counter 0..SCAN_WAIT-1 runs freely and ignores i_run, i_clr and i_load.
  - On its last value, digit index idx advances 0→1→…→DIGITS-1→0.
- Display:
  - o_dig is registered, = ~(1<<idx).
  - o_seg is registered, = the pattern of digit idx of the count.
- Patterns (0–9): 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110.
- Blanking (BLANK_LZ=1): digit k>0 shows 00000000 when it and every digit above it are 0.
- States: the count does not use an FSM. It is RUN or PAUSE as a function of i_run only.

## Timing
- Reset values (asynchronous, immediate):
  - prescaler=0, scan counter=0, idx=0, count=0
  - o_bcd=0, o_wrap=0, o_dig=~1 (…1110), o_seg=11111100
- o_bcd is the count register itself; it updates on the step, clear or load edge.
- o_wrap is registered and goes high on the same edge o_bcd wraps, for exactly 1 cycle.
- o_seg/o_dig have 1 cycle of latency from idx or count change, and always change together, so there is no ghosting.
- Step period: exactly TICK_WAIT cycles of i_run=1.
- Digit dwell: exactly SCAN_WAIT cycles. Frame: DIGITS*SCAN_WAIT cycles.
- Releasing w_rst mid-operation: counting resumes from a full TICK_WAIT period. There is no partial first period.

## Test plan
Test configuration: DIGITS=3, TICK_WAIT=4, SCAN_WAIT=3.
- Reset check: assert w_rst with no clock → o_bcd=000, o_wrap=0, o_dig=110, o_seg=11111100 immediately.
- Up counting: i_run=1, i_up=1 from 000 → o_bcd=001 after 4 cycles.
  - Load 099, then one step → 100.
  - Load 999, then one step → 000 with o_wrap high for exactly 1 cycle.
- Down counting: i_up=0 from 000 → 999 with o_wrap pulse. From 100 → 099.
- Pause: i_run=0 for 10 cycles mid-period → o_bcd unchanged. The step lands exactly when 4 total run cycles have elapsed.
- Priorities:
  - i_load with i_load_val=0x1A5 → o_bcd=0x195.
  - i_clr and i_load together with a pending step → o_bcd=000, no o_wrap.
- Scan and blanking:
  - Count 305 → o_dig sequence 110,101,011 at 3 cycles each; o_seg = 10110110, 11111100, 11110010.
  - BLANK_LZ=1 with count 005 → digits 1 and 2 show 00000000; digit 0 shows 10110110.
- Mid-run reset: pulse w_rst mid-count → all outputs at reset values asynchronously. Counting restarts with first step 4 cycles after release.

Source files
------------

// File: rtl/seg7_bcd_counter.sv
// N-digit BCD up/down counter with a time-multiplexed common-segment
// 7-segment display driver (active-low one-hot digit select).
module seg7_bcd_counter #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_WAIT = 27_000_000,
  parameter int unsigned SCAN_WAIT = 27_000,
  parameter bit          BLANK_LZ  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  w_rst,
  input  logic                  i_run,
  input  logic                  i_up,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_wrap,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_WAIT > 1) ? $clog2(TICK_WAIT) : 1;
  localparam int unsigned SW = (SCAN_WAIT > 1) ? $clog2(SCAN_WAIT) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_WAIT - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_WAIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;

  logic [BW-1:0] step_bcd;
  logic [BW-1:0] load_sat;
  logic          carry;
  logic [3:0]    cur_nib;
  logic [3:0]    cur_digit;
  logic          upper_zero;
  logic          blank;
  logic          step;

  // Segment pattern {a,b,c,d,e,f,g,dp} for one BCD digit.
  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 8'b1111_1100;
      4'd1:    seg_pat = 8'b0110_0000;
      4'd2:    seg_pat = 8'b1101_1010;
      4'd3:    seg_pat = 8'b1111_0010;
      4'd4:    seg_pat = 8'b0110_0110;
      4'd5:    seg_pat = 8'b1011_0110;
      4'd6:    seg_pat = 8'b1011_1110;
      4'd7:    seg_pat = 8'b1110_0000;
      4'd8:    seg_pat = 8'b1111_1110;
      4'd9:    seg_pat = 8'b1111_0110;
      default: seg_pat = 8'b0000_0000;
    endcase
  endfunction

  assign step = i_run && (presc == PRESC_LAST);

  // Next count for one step: decimal carry/borrow ripple from the units digit.
  always_comb begin
    step_bcd = o_bcd;
    carry    = 1'b1;
    cur_nib  = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      cur_nib = o_bcd[4*k +: 4];
      if (carry) begin
        if (i_up) begin
          if (cur_nib >= 4'd9) begin
            step_bcd[4*k +: 4] = 4'd0;
          end else begin
            step_bcd[4*k +: 4] = cur_nib + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (cur_nib == 4'd0) begin
            step_bcd[4*k +: 4] = 4'd9;
          end else begin
            step_bcd[4*k +: 4] = cur_nib - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  // Load value with out-of-range nibbles saturated to 9.
  always_comb begin
    load_sat = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_sat[4*k +: 4] = (i_load_val[4*k +: 4] > 4'd9) ? 4'd9 : i_load_val[4*k +: 4];
    end
  end

  // Count register, prescaler and wrap pulse; clear beats load beats step.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      presc  <= '0;
      o_bcd  <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= 1'b0;
      if (i_clr) begin
        presc <= '0;
        o_bcd <= '0;
      end else if (i_load) begin
        presc <= '0;
        o_bcd <= load_sat;
      end else if (step) begin
        presc  <= '0;
        o_bcd  <= step_bcd;
        o_wrap <= carry;
      end else if (i_run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Free-running scan timer and digit index.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Select the scanned digit and decide whether it is a blanked leading zero.
  always_comb begin
    cur_digit  = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx) begin
        cur_digit = o_bcd[4*k +: 4];
      end
      if ((k >= int'(idx)) && (o_bcd[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = BLANK_LZ && (idx != '0) && upper_zero;
  end

  // Segment and digit lines registered together so they switch on the same edge.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      o_seg <= seg_pat(4'd0);
      o_dig <= ~DIGITS'(1);
    end else begin
      o_seg <= blank ? 8'b0000_0000 : seg_pat(cur_digit);
      o_dig <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Scoreboard bench for seg7_bcd_counter (3 digits, 4-cycle step, 3-cycle dwell).
module tb_seg7_bcd_counter;

  localparam int unsigned D  = 3;
  localparam int unsigned TW = 4;
  localparam int unsigned SW = 3;

  logic          i_clk = 1'b0;
  logic          w_rst = 1'b0;
  logic          i_run = 1'b0;
  logic          i_up  = 1'b1;
  logic          i_clr = 1'b0;
  logic          i_load = 1'b0;
  logic [11:0]   i_load_val = 12'h000;

  logic [11:0] bcd_a, bcd_b;
  logic        wrap_a, wrap_b;
  logic [7:0]  seg_a, seg_b;
  logic [2:0]  dig_a, dig_b;

  seg7_bcd_counter #(.DIGITS(D), .TICK_WAIT(TW), .SCAN_WAIT(SW), .BLANK_LZ(1'b0)) u_dut (
    .i_clk(i_clk), .w_rst(w_rst), .i_run(i_run), .i_up(i_up), .i_clr(i_clr),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_bcd(bcd_a), .o_wrap(wrap_a), .o_seg(seg_a), .o_dig(dig_a)
  );

  seg7_bcd_counter #(.DIGITS(D), .TICK_WAIT(TW), .SCAN_WAIT(SW), .BLANK_LZ(1'b1)) u_dut_blk (
    .i_clk(i_clk), .w_rst(w_rst), .i_run(i_run), .i_up(i_up), .i_clr(i_clr),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_bcd(bcd_b), .o_wrap(wrap_b), .o_seg(seg_b), .o_dig(dig_b)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] bcd;
    logic        wrap;
    logic [7:0]  seg_a;
    logic [7:0]  seg_b;
    logic [2:0]  dig;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] pat [10];

  // Reference state: count as a plain integer 0..999.
  int m_v, m_p, m_scan, m_idx;
  logic m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_val(input logic [11:0] lv);
    int r;
    logic [3:0] n;
    r = 0;
    for (int k = 2; k >= 0; k--) begin
      n = lv[4*k +: 4];
      r = r * 10 + ((n > 4'd9) ? 9 : int'(n));
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  task automatic model_reset();
    m_v = 0; m_p = 0; m_scan = 0; m_idx = 0; m_wrap = 1'b0;
    sb.delete();
  endtask

  // Predict one edge, push the expectation, then compare after the edge.
  task automatic cycle();
    exp_t e, o;
    int d;
    d       = digit_of(m_v, m_idx);
    e.dig   = ~(3'b001 << m_idx);
    e.seg_a = pat[d];
    e.seg_b = (m_idx > 0 && m_v < pow10(m_idx)) ? 8'h00 : pat[d];
    m_wrap  = 1'b0;
    if (i_clr) begin
      m_v = 0; m_p = 0;
    end else if (i_load) begin
      m_v = sat_val(i_load_val); m_p = 0;
    end else if (i_run) begin
      if (m_p == TW - 1) begin
        m_p = 0;
        if (i_up) begin
          m_wrap = (m_v == 999);
          m_v    = (m_v + 1) % 1000;
        end else begin
          m_wrap = (m_v == 0);
          m_v    = (m_v + 999) % 1000;
        end
      end else begin
        m_p++;
      end
    end
    if (m_scan == SW - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % D;
    end else begin
      m_scan++;
    end
    e.bcd  = to_bcd(m_v);
    e.wrap = m_wrap;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    o = sb.pop_front();
    check("sb_bcd",   32'(bcd_a),  32'(o.bcd));
    check("sb_bcd_b", 32'(bcd_b),  32'(o.bcd));
    check("sb_wrap",  32'(wrap_a), 32'(o.wrap));
    check("sb_dig",   32'(dig_a),  32'(o.dig));
    check("sb_dig_b", 32'(dig_b),  32'(o.dig));
    check("sb_seg",   32'(seg_a),  32'(o.seg_a));
    check("sb_seg_b", 32'(seg_b),  32'(o.seg_b));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [11:0] v);
    i_load_val = v;
    i_load     = 1'b1;
    cycle();
    i_load     = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bcd"},  32'(bcd_a),  32'h000);
    check({tag, "_wrap"}, 32'(wrap_a), 32'h0);
    check({tag, "_dig"},  32'(dig_a),  32'b110);
    check({tag, "_seg"},  32'(seg_a),  32'b1111_1100);
    check({tag, "_segb"}, 32'(seg_b),  32'b1111_1100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pat[0] = 8'b1111_1100; pat[1] = 8'b0110_0000; pat[2] = 8'b1101_1010;
    pat[3] = 8'b1111_0010; pat[4] = 8'b0110_0110; pat[5] = 8'b1011_0110;
    pat[6] = 8'b1011_1110; pat[7] = 8'b1110_0000; pat[8] = 8'b1111_1110;
    pat[9] = 8'b1111_0110;

    // Asynchronous reset before any clock edge.
    #2 w_rst = 1'b1;
    #1 check_reset_vals("rst");
    @(posedge i_clk);
    @(negedge i_clk);
    w_rst = 1'b0;
    model_reset();

    // Up counting from 000.
    i_run = 1'b1; i_up = 1'b1;
    cycles(3);
    check("up_pre", 32'(bcd_a), 32'h000);
    cycle();
    check("up_first", 32'(bcd_a), 32'h001);

    do_load(12'h099);
    cycles(4);
    check("up_099", 32'(bcd_a), 32'h100);

    do_load(12'h999);
    cycles(4);
    check("up_wrap_val", 32'(bcd_a), 32'h000);
    check("up_wrap_hi",  32'(wrap_a), 32'h1);
    cycle();
    check("up_wrap_lo",  32'(wrap_a), 32'h0);

    // Down counting.
    i_clr = 1'b1; cycle(); i_clr = 1'b0;
    i_up = 1'b0;
    cycles(4);
    check("dn_wrap_val", 32'(bcd_a), 32'h999);
    check("dn_wrap_hi",  32'(wrap_a), 32'h1);
    do_load(12'h100);
    cycles(4);
    check("dn_100", 32'(bcd_a), 32'h099);

    // Pause mid-period.
    i_up = 1'b1;
    do_load(12'h000);
    cycles(2);
    i_run = 1'b0;
    cycles(10);
    check("pause_hold", 32'(bcd_a), 32'h000);
    i_run = 1'b1;
    cycle();
    check("pause_early", 32'(bcd_a), 32'h000);
    cycle();
    check("pause_step", 32'(bcd_a), 32'h001);

    // Load saturation and clear/load priority over a pending step.
    do_load(12'h1A5);
    check("load_sat", 32'(bcd_a), 32'h195);
    do_load(12'h999);
    cycles(3);
    i_clr = 1'b1; i_load = 1'b1; i_load_val = 12'h999;
    cycle();
    i_clr = 1'b0; i_load = 1'b0;
    check("clr_prio", 32'(bcd_a), 32'h000);
    check("clr_nowrap", 32'(wrap_a), 32'h0);

    // Scan of 305, then leading-zero blanking of 005.
    i_run = 1'b0;
    do_load(12'h305);
    cycles(12);
    do_load(12'h005);
    cycles(12);
    do_load(12'h040);
    cycles(9);

    // Mid-run reset.
    i_run = 1'b1; i_up = 1'b1;
    do_load(12'h123);
    cycles(2);
    #2 w_rst = 1'b1;
    #1 check_reset_vals("mrst");
    @(posedge i_clk);
    #1 check_reset_vals("mrst_hold");
    @(negedge i_clk);
    w_rst = 1'b0;
    model_reset();
    cycles(3);
    check("mrst_pre", 32'(bcd_a), 32'h000);
    cycle();
    check("mrst_first", 32'(bcd_a), 32'h001);
    cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
